ekf_stage_seq: RTL and testbench
================================

# ekf_stage_seq

Command sequencer directly upstream of the EKF-SLAM `Top` core. It fetches stage commands from a command BRAM and drives `Top`'s `stage_val`, `l_k`, `landmark_num`, `vlr`, `alpha`, `rk` and `phi` inputs. It waits for the matching `stage_rdy` before fetching the next command. It also owns the running landmark count, incrementing it after every completed NEW stage.

## Interface
Parameters:
- `RSA_DW`, default 32: operand width, Q1.12.19.
- `RSA_AW`, default 17: angle/alpha width.
- `ROW_LEN`, default 10: width of `l_k` and `landmark_num`.
- `CMD_AW`, default 10: command BRAM address width.
- `VAL_LEN`, default 2: length of the `stage_val` pulse in cycles.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `sys_rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that starts list execution.
- `abort`, in, 1: level; returns the block to IDLE.
- `cmd_base`, in, CMD_AW: address of the first header word.
- `lm_init`, in, ROW_LEN: landmark count loaded on `start`.
- `cmd_en`, out, 1: BRAM read enable.
- `cmd_addr`, out, CMD_AW: BRAM read address.
- `cmd_dout`, in, 32: BRAM read data. Read latency is 1 cycle.
- `stage_val`, out, 3: stage code issued to `Top`.
- `stage_rdy`, in, 3: stage completion code from `Top`.
- `l_k`, out, ROW_LEN: landmark index for the current command.
- `landmark_num`, out, ROW_LEN: running landmark count.
- `vlr`, out, RSA_DW: PRD velocity operand.
- `alpha`, out, RSA_AW: PRD steering operand.
- `rk`, out, RSA_DW: observation range.
- `phi`, out, RSA_AW: observation bearing.
- `busy`, out, 1: high from the `start` edge until DONE, ERR or abort.
- `done`, out, 1: one-cycle pulse after the last command completes.
- `err`, out, 1: sticky; set on an illegal stage code, cleared by `start`.

## Operation
Each command is 3 consecutive words: header, op0, op1.
- Header fields:
  - `[2:0]`: stage code. PRD=1, NEW=2, UPD=3, ASSOC=4.
  - `[ROW_LEN+2:3]`: `l_k`.
  - `[31]`: last-command flag.
- PRD: op0 drives `vlr`; `op1[RSA_AW-1:0]` drives `alpha`. `rk` and `phi` keep their previous values.
- NEW, UPD, ASSOC: op0 drives `rk`; `op1[RSA_AW-1:0]` drives `phi`. `vlr` and `alpha` keep their previous values.

State machine:
- IDLE: on `start`, load the address pointer from `cmd_base`, load the count from `lm_init`, clear `err`, go to FETCH. `start` while busy is ignored.
- FETCH: issue 3 reads on consecutive cycles; capture 3 words on the following cycles. Then go to DECODE.
- DECODE: illegal code (0, 5, 6, 7) → ERR. Otherwise latch operands and `l_k`, go to ISSUE.
- ISSUE: hold `stage_val` = code for exactly `VAL_LEN` cycles, then go to WAIT.
- WAIT: wait for `stage_rdy` == issued code. On a match:
  - NEW: `landmark_num` += 1, saturating at 2^ROW_LEN−1.
  - If the last flag is set, go to DONE; else advance the pointer by 3 and go to FETCH.
- DONE: pulse `done`, go to IDLE.
- ERR: set `err`, drop `busy`, go to IDLE. `stage_val` is not asserted for the bad command.

Completion matching:
- `stage_rdy` values other than the issued code are ignored, as is 0.
- A match during ISSUE counts as completion. The pulse still runs its full `VAL_LEN`.

Other rules:
- `abort` overrides every state. Next cycle: IDLE, `stage_val`=0, `cmd_en`=0, no `done`. `landmark_num` and operands are retained.
- `cmd_addr` wraps modulo 2^CMD_AW.

## Timing
- Reset: every output is 0 (`landmark_num`, operands, `err` included).
- `start` sampled at edge E0:
  - `cmd_en` is high during cycles E0+1, E0+2, E0+3, with `cmd_addr` = base, base+1, base+2.
  - Data is captured at E0+2, E0+3, E0+4.
  - DECODE occurs at E0+5.
  - `stage_val` is high for cycles E0+6 … E0+5+VAL_LEN.
- Operands, `l_k` and `landmark_num` are stable from the first `stage_val` cycle until the next DECODE.
- Matching `stage_rdy` sampled at edge R:
  - The `landmark_num` update is visible at R+1.
  - The next fetch starts at R+1 (`cmd_en` high).
  - The next `stage_val` rises at R+6.
- `done` is high for 1 cycle at R+1 of the last command; `busy` falls in the same cycle.

## Structure
- Shared package `ekf_pkg` holds:
  - stage codes, including IDLE=0;
  - header field positions and the last-flag bit;
  - the FSM state enum.
- Sub-module `ekf_cmd_fetch` is natural: a 3-word read pipeline with pointer, wrap and capture registers, and a `fetch_go`/`fetch_done` handshake.

## Test plan
- Single PRD command with base=0, header=0x8000_0011, op0=0x0010_0000, op1=0x0002_0000:
  - `stage_val`=1 for 2 cycles starting at E0+6;
  - `l_k`=2, `vlr`=0x0010_0000, `alpha`=0x0_0000 (low 17 bits of op1);
  - `stage_rdy`=1 → `done` pulse, `busy`=0.
- List NEW, NEW, ASSOC with `lm_init`=4, landmark_num ending at 6; `stage_rdy`=4 during the NEW wait is ignored.
- Header code 6 in the second command → `err`=1, only one `stage_val` pulse seen, `busy` drops.
- `cmd_base`=1022:
  - `cmd_addr` sequence is 1022, 1023, 0;
  - the second command fetches 1, 2, 3.
- `abort` during WAIT → next cycle IDLE, `stage_val`=0, no `done`; a later `start` runs normally.
- `lm_init`=1023 with a NEW completion → `landmark_num` stays 1023. Asserting `sys_rst` mid-ISSUE clears all outputs asynchronously.

Source files
------------

// File: rtl/ekf_pkg.sv
// Shared definitions for the EKF-SLAM command sequencer: stage codes,
// command header layout and sequencer FSM states.
package ekf_pkg;

  typedef enum logic [2:0] {
    STG_IDLE  = 3'd0,
    STG_PRD   = 3'd1,
    STG_NEW   = 3'd2,
    STG_UPD   = 3'd3,
    STG_ASSOC = 3'd4
  } stage_e;

  localparam int HDR_CODE_LSB = 0;
  localparam int HDR_LK_LSB   = 3;
  localparam int HDR_LAST_BIT = 31;
  localparam int CMD_WORDS    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } seq_state_e;

  function automatic logic is_legal_stage(input logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd4);
  endfunction

endpackage

// File: rtl/ekf_cmd_fetch.sv
// Three-word command read pipeline: owns the list pointer, issues reads to a
// 1-cycle-latency BRAM and captures header/op0/op1.
module ekf_cmd_fetch
  import ekf_pkg::*;
#(
  parameter int CMD_AW = 10
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              clear,
  input  logic              load,
  input  logic [CMD_AW-1:0] base,
  input  logic              go,
  input  logic              adv,
  output logic              cmd_en,
  output logic [CMD_AW-1:0] cmd_addr,
  input  logic [31:0]       cmd_dout,
  output logic              fetch_done,
  output logic [31:0]       hdr,
  output logic [31:0]       op0,
  output logic [31:0]       op1
);

  logic [CMD_AW-1:0] ptr;
  logic              rd_active;
  logic [1:0]        rd_idx;
  logic              cap_vld;
  logic [1:0]        cap_idx;

  assign cmd_en     = rd_active;
  // Address arithmetic is CMD_AW wide, so running off the top wraps to 0.
  assign cmd_addr   = ptr + CMD_AW'(rd_idx);
  assign fetch_done = cap_vld && (cap_idx == 2'd2);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      ptr       <= '0;
      rd_active <= 1'b0;
      rd_idx    <= '0;
      cap_vld   <= 1'b0;
      cap_idx   <= '0;
      // NOTE: the capture words are a handful of flops, not a RAM, so they
      // take reset like everything else and never leak X into the operands.
      hdr       <= '0;
      op0       <= '0;
      op1       <= '0;
    end else begin
      if (load)     ptr <= base;
      else if (adv) ptr <= ptr + CMD_AW'(CMD_WORDS);

      if (clear) begin
        rd_active <= 1'b0;
        rd_idx    <= '0;
        cap_vld   <= 1'b0;
        cap_idx   <= '0;
      end else begin
        if (go) begin
          rd_active <= 1'b1;
          rd_idx    <= '0;
        end else if (rd_active) begin
          rd_idx <= rd_idx + 2'd1;
          if (rd_idx == 2'd2) rd_active <= 1'b0;
        end
        // Read data returns one cycle after the enable; track which word it is.
        cap_vld <= rd_active;
        cap_idx <= rd_idx;
        if (cap_vld) begin
          case (cap_idx)
            2'd0:    hdr <= cmd_dout;
            2'd1:    op0 <= cmd_dout;
            default: op1 <= cmd_dout;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/ekf_stage_seq.sv
// Stage command sequencer feeding the EKF-SLAM Top core: fetches commands,
// issues stage_val pulses, waits for stage_rdy and tracks the landmark count.
module ekf_stage_seq
  import ekf_pkg::*;
#(
  parameter int RSA_DW  = 32,
  parameter int RSA_AW  = 17,
  parameter int ROW_LEN = 10,
  parameter int CMD_AW  = 10,
  parameter int VAL_LEN = 2
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CMD_AW-1:0]  cmd_base,
  input  logic [ROW_LEN-1:0] lm_init,
  output logic               cmd_en,
  output logic [CMD_AW-1:0]  cmd_addr,
  input  logic [31:0]        cmd_dout,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  output logic [ROW_LEN-1:0] l_k,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic [RSA_DW-1:0]  vlr,
  output logic [RSA_AW-1:0]  alpha,
  output logic [RSA_DW-1:0]  rk,
  output logic [RSA_AW-1:0]  phi,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int VC_W = $clog2(VAL_LEN + 1);
  localparam logic [VC_W-1:0] VAL_LAST = VC_W'(VAL_LEN - 1);

  seq_state_e  state, state_nxt;
  logic        fetch_go, fetch_load, fetch_adv, fetch_done;
  logic [31:0] hdr, op0, op1;
  logic        start_run, latch_cmd, set_err, complete;
  logic [2:0]  cur_code;
  logic        last_flag;
  logic        rdy_seen;
  logic [VC_W-1:0] val_cnt;
  logic [2:0]  hdr_code;
  logic        rdy_hit;
  logic        unused_hdr_bits;

  assign hdr_code        = hdr[HDR_CODE_LSB +: 3];
  assign rdy_hit         = (stage_rdy == cur_code);
  assign unused_hdr_bits = ^{hdr[HDR_LAST_BIT-1:HDR_LK_LSB+ROW_LEN], op1[31:RSA_AW]};

  ekf_cmd_fetch #(.CMD_AW(CMD_AW)) u_fetch (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .clear      (abort),
    .load       (fetch_load),
    .base       (cmd_base),
    .go         (fetch_go),
    .adv        (fetch_adv),
    .cmd_en     (cmd_en),
    .cmd_addr   (cmd_addr),
    .cmd_dout   (cmd_dout),
    .fetch_done (fetch_done),
    .hdr        (hdr),
    .op0        (op0),
    .op1        (op1)
  );

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    state_nxt  = state;
    fetch_go   = 1'b0;
    fetch_load = 1'b0;
    fetch_adv  = 1'b0;
    start_run  = 1'b0;
    latch_cmd  = 1'b0;
    set_err    = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nxt  = S_FETCH;
        fetch_go   = 1'b1;
        fetch_load = 1'b1;
        start_run  = 1'b1;
      end
      S_FETCH:  if (fetch_done) state_nxt = S_DECODE;
      S_DECODE: if (is_legal_stage(hdr_code)) begin
        latch_cmd = 1'b1;
        state_nxt = S_ISSUE;
      end else begin
        set_err   = 1'b1;
        state_nxt = S_ERR;
      end
      S_ISSUE:  if (val_cnt == VAL_LAST) state_nxt = S_WAIT;
      S_WAIT: if (rdy_seen || rdy_hit) begin
        complete = 1'b1;
        if (last_flag) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_FETCH;
          fetch_go  = 1'b1;
          fetch_adv = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort wins over everything, including the side effects above.
    if (abort) begin
      state_nxt  = S_IDLE;
      fetch_go   = 1'b0;
      fetch_load = 1'b0;
      fetch_adv  = 1'b0;
      start_run  = 1'b0;
      latch_cmd  = 1'b0;
      set_err    = 1'b0;
      complete   = 1'b0;
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      cur_code     <= '0;
      last_flag    <= 1'b0;
      rdy_seen     <= 1'b0;
      val_cnt      <= '0;
      l_k          <= '0;
      landmark_num <= '0;
      vlr          <= '0;
      alpha        <= '0;
      rk           <= '0;
      phi          <= '0;
      err          <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_run) begin
        landmark_num <= lm_init;
        err          <= 1'b0;
      end
      if (set_err) err <= 1'b1;
      if (latch_cmd) begin
        cur_code  <= hdr_code;
        last_flag <= hdr[HDR_LAST_BIT];
        l_k       <= hdr[HDR_LK_LSB +: ROW_LEN];
        val_cnt   <= '0;
        rdy_seen  <= 1'b0;
        if (hdr_code == STG_PRD) begin
          vlr   <= op0[RSA_DW-1:0];
          alpha <= op1[RSA_AW-1:0];
        end else begin
          rk    <= op0[RSA_DW-1:0];
          phi   <= op1[RSA_AW-1:0];
        end
      end
      // An early completion is remembered; the pulse still runs full length.
      if (state == S_ISSUE) begin
        val_cnt <= val_cnt + 1'b1;
        if (rdy_hit) rdy_seen <= 1'b1;
      end
      if (complete && (cur_code == STG_NEW) && (landmark_num != '1))
        landmark_num <= landmark_num + 1'b1;
    end
  end

  assign stage_val = (state == S_ISSUE) ? cur_code : 3'd0;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_ISSUE) || (state == S_WAIT);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_ekf_stage_seq.sv
// Self-checking bench for ekf_stage_seq: directed scenarios plus randomized
// command lists checked against a command-level reference model.
module tb_ekf_stage_seq;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start, abort;
  logic [9:0]  cmd_base, lm_init;
  logic        cmd_en;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_dout;
  logic [2:0]  stage_val, stage_rdy;
  logic [9:0]  l_k, landmark_num;
  logic [31:0] vlr, rk;
  logic [16:0] alpha, phi;
  logic        busy, done, err;

  ekf_stage_seq dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .cmd_base(cmd_base), .lm_init(lm_init), .cmd_en(cmd_en),
    .cmd_addr(cmd_addr), .cmd_dout(cmd_dout), .stage_val(stage_val),
    .stage_rdy(stage_rdy), .l_k(l_k), .landmark_num(landmark_num),
    .vlr(vlr), .alpha(alpha), .rk(rk), .phi(phi),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Command BRAM with 1-cycle read latency.
  logic [31:0] mem [1024];
  always @(posedge clk) if (cmd_en) cmd_dout <= mem[cmd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Command list and per-command stimulus knobs.
  int          cmd_code  [8];
  logic [9:0]  cmd_lk    [8];
  logic [31:0] cmd_op0   [8];
  logic [31:0] cmd_op1   [8];
  bit          cmd_early [8];
  logic [2:0]  cmd_wrong [8];
  int          cmd_wcyc  [8];

  // Reference model state.
  logic [31:0] exp_vlr, exp_rk;
  logic [16:0] exp_alpha, exp_phi;
  logic [9:0]  exp_lm;

  task automatic set_cmd(input int i, input int code, input logic [9:0] lk,
                         input logic [31:0] o0, input logic [31:0] o1,
                         input bit early, input logic [2:0] wrong, input int wcyc);
    cmd_code[i] = code; cmd_lk[i] = lk; cmd_op0[i] = o0; cmd_op1[i] = o1;
    cmd_early[i] = early; cmd_wrong[i] = wrong; cmd_wcyc[i] = wcyc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stage_val"}, stage_val, 0);
    check({tag, "_cmd_en"}, cmd_en, 0);
    check({tag, "_cmd_addr"}, cmd_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_l_k"}, l_k, 0);
    check({tag, "_lm"}, landmark_num, 0);
    check({tag, "_vlr"}, vlr, 0);
    check({tag, "_alpha"}, alpha, 0);
    check({tag, "_rk"}, rk, 0);
    check({tag, "_phi"}, phi, 0);
  endtask

  // Runs one list from IDLE; checks the cycle-level timing of every command.
  task automatic run_list(input int base, input int n, input logic [9:0] lm0,
                          input int abort_idx, input int rst_idx);
    int addr;
    bit legal;
    for (int i = 0; i < n; i++) begin
      addr = (base + 3 * i) % 1024;
      mem[addr]              = {(i == n - 1), 18'd0, cmd_lk[i], 3'(cmd_code[i])};
      mem[(addr + 1) % 1024] = cmd_op0[i];
      mem[(addr + 2) % 1024] = cmd_op1[i];
    end
    @(negedge clk);
    start = 1'b1; cmd_base = 10'(base); lm_init = lm0;
    @(posedge clk); #1;
    start = 1'b0;
    exp_lm = lm0;
    check("start_err_clr", err, 0);
    for (int i = 0; i < n; i++) begin
      addr  = (base + 3 * i) % 1024;
      legal = (cmd_code[i] >= 1) && (cmd_code[i] <= 4);
      for (int k = 0; k < 3; k++) begin
        check("fetch_en", cmd_en, 1);
        check("fetch_addr", cmd_addr, (addr + k) % 1024);
        check("fetch_busy", busy, 1);
        @(posedge clk); #1;
      end
      check("fetch_en_off", cmd_en, 0);
      @(posedge clk); #1;
      check("decode_sv", stage_val, 0);
      @(posedge clk); #1;
      if (!legal) begin
        check("err_set", err, 1);
        check("err_busy", busy, 0);
        check("err_sv", stage_val, 0);
        check("err_done", done, 0);
        @(posedge clk); #1;
        check("err_sticky", err, 1);
        check("err_idle_busy", busy, 0);
        check("err_idle_en", cmd_en, 0);
        return;
      end
      if (cmd_code[i] == 1) begin
        exp_vlr = cmd_op0[i]; exp_alpha = cmd_op1[i][16:0];
      end else begin
        exp_rk = cmd_op0[i]; exp_phi = cmd_op1[i][16:0];
      end
      check("issue_sv", stage_val, cmd_code[i]);
      check("issue_lk", l_k, cmd_lk[i]);
      check("issue_vlr", vlr, exp_vlr);
      check("issue_alpha", alpha, exp_alpha);
      check("issue_rk", rk, exp_rk);
      check("issue_phi", phi, exp_phi);
      check("issue_lm", landmark_num, exp_lm);
      if (rst_idx == i) begin
        #2 sys_rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk); sys_rst = 1'b0;
        exp_vlr = 0; exp_rk = 0; exp_alpha = 0; exp_phi = 0; exp_lm = 0;
        return;
      end
      if (cmd_early[i]) stage_rdy = 3'(cmd_code[i]);
      @(posedge clk); #1;
      stage_rdy = 3'd0;
      check("issue_sv2", stage_val, cmd_code[i]);
      @(posedge clk); #1;
      check("wait_sv", stage_val, 0);
      check("wait_busy", busy, 1);
      if (abort_idx == i) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_sv", stage_val, 0);
        check("abort_en", cmd_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_lm", landmark_num, exp_lm);
        check("abort_rk", rk, exp_rk);
        @(posedge clk); #1;
        check("abort_done2", done, 0);
        check("abort_busy2", busy, 0);
        return;
      end
      if (!cmd_early[i]) begin
        stage_rdy = cmd_wrong[i];
        start = 1'b1; lm_init = ~lm0;
        for (int w = 0; w < cmd_wcyc[i]; w++) begin
          @(posedge clk); #1;
          start = 1'b0;
          check("ignore_sv", stage_val, 0);
          check("ignore_en", cmd_en, 0);
          check("ignore_busy", busy, 1);
          check("ignore_done", done, 0);
          check("ignore_lm", landmark_num, exp_lm);
        end
        stage_rdy = 3'(cmd_code[i]);
      end
      @(posedge clk); #1;
      stage_rdy = 3'd0;
      if (cmd_code[i] == 2 && exp_lm != 10'd1023) exp_lm = exp_lm + 10'd1;
      check("cmpl_lm", landmark_num, exp_lm);
      if (i == n - 1) begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_en", cmd_en, 0);
        @(posedge clk); #1;
        check("done_off", done, 0);
        check("done_idle_busy", busy, 0);
        check("done_lm_hold", landmark_num, exp_lm);
      end
    end
  endtask

  function automatic logic [2:0] pick_wrong(input int code);
    logic [2:0] w;
    w = 3'($urandom_range(0, 7));
    if (int'(w) == code) w = w + 3'd1;
    return w;
  endfunction

  initial begin
    int n;
    int code;
    sys_rst = 1'b1; start = 1'b0; abort = 1'b0;
    cmd_base = '0; lm_init = '0; stage_rdy = '0;
    exp_vlr = 0; exp_rk = 0; exp_alpha = 0; exp_phi = 0; exp_lm = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
    #12;
    check_all_zero("reset");
    @(negedge clk); sys_rst = 1'b0;

    // Single PRD command at base 0.
    set_cmd(0, 1, 10'd2, 32'h0010_0000, 32'h0002_0000, 0, 3'd0, 1);
    run_list(0, 1, 10'd7, -1, -1);
    check("prd_mem_hdr", mem[0], 32'h8000_0011);

    // NEW, NEW, ASSOC with a stray ASSOC ready during the first NEW wait.
    set_cmd(0, 2, 10'd5, 32'h1111_0000, 32'h0001_2345, 0, 3'd4, 2);
    set_cmd(1, 2, 10'd6, 32'h2222_0000, 32'h0000_0777, 1, 3'd0, 1);
    set_cmd(2, 4, 10'd3, 32'h3333_0000, 32'h0001_ffff, 0, 3'd0, 1);
    run_list(40, 3, 10'd4, -1, -1);
    check("new_new_assoc_lm", landmark_num, 10'd6);

    // Illegal code 6 in the second command.
    set_cmd(0, 3, 10'd9, 32'h4444_0000, 32'h0000_1234, 0, 3'd1, 1);
    set_cmd(1, 6, 10'd1, 32'h5555_0000, 32'h0000_0001, 0, 3'd0, 1);
    run_list(100, 2, 10'd0, -1, -1);

    // Address wrap from base 1022.
    set_cmd(0, 1, 10'd11, 32'hdead_beef, 32'hffff_ffff, 0, 3'd3, 1);
    set_cmd(1, 3, 10'd12, 32'hcafe_f00d, 32'h0000_5555, 1, 3'd0, 1);
    run_list(1022, 2, 10'd20, -1, -1);

    // Abort in WAIT, then a clean run.
    set_cmd(0, 2, 10'd1, 32'h0101_0101, 32'h0000_0101, 0, 3'd0, 1);
    set_cmd(1, 3, 10'd2, 32'h0202_0202, 32'h0000_0202, 0, 3'd0, 1);
    run_list(200, 2, 10'd30, 0, -1);
    run_list(200, 2, 10'd30, -1, -1);

    // Saturating landmark count.
    set_cmd(0, 2, 10'd3, 32'h0303_0303, 32'h0000_0303, 0, 3'd1, 1);
    run_list(300, 1, 10'd1023, -1, -1);
    check("sat_lm", landmark_num, 10'd1023);

    // Randomized lists.
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        code = $urandom_range(1, 4);
        set_cmd(i, code, 10'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)),
                pick_wrong(code), $urandom_range(1, 3));
      end
      run_list($urandom_range(0, 1023), n, 10'($urandom), -1, -1);
    end

    // Asynchronous reset in the middle of ISSUE.
    set_cmd(0, 1, 10'd77, 32'h7777_7777, 32'h0000_7777, 0, 3'd0, 1);
    run_list(500, 1, 10'd50, -1, 0);
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_lm", landmark_num, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
